// File: rtl/ddr_burst_reader.sv
// Avalon-MM burst read master that fetches one half of the DDR3 sample buffer
// and streams it out through a show-ahead FIFO, pulsing a per-half switch flag when done.
module ddr_burst_reader #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 64,
  parameter int BURST        = 4,
  parameter int REGION_WORDS = 4096,
  parameter int L_BASE       = 0,
  parameter int H_BASE       = 4096,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              rd_start_l,
  input  logic              rd_start_h,
  input  logic              avl_ready,
  output logic [ADDR_W-1:0] avl_addr,
  output logic              avl_read_req,
  output logic              avl_burstbegin,
  output logic [3:0]        avl_size,
  output logic [7:0]        avl_be,
  input  logic [DATA_W-1:0] avl_rdata,
  input  logic              avl_rdata_valid,
  output logic [DATA_W-1:0] dat_out,
  output logic              dat_en,
  input  logic              dat_ready,
  output logic              read_switch_l,
  output logic              read_switch_h,
  output logic              busy
);

  localparam int NREQ = REGION_WORDS / BURST;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int XW   = CW + 1;
  localparam int RW   = $clog2(NREQ + 1);
  localparam int PCW  = $clog2(REGION_WORDS + 1);

  localparam logic [CW-1:0]     BURST_C  = CW'(BURST);
  localparam logic [XW-1:0]     BURST_X  = XW'(BURST);
  localparam logic [XW-1:0]     DEPTH_X  = XW'(FIFO_DEPTH);
  localparam logic [RW-1:0]     LAST_REQ = RW'(NREQ - 1);
  localparam logic [PCW-1:0]    LAST_POP = PCW'(REGION_WORDS - 1);
  localparam logic [ADDR_W-1:0] L_ADDR   = ADDR_W'(L_BASE);
  localparam logic [ADDR_W-1:0] H_ADDR   = ADDR_W'(H_BASE);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t             state_q;
  logic               half_q;
  logic               pend_q;
  logic               busy_q;
  logic               req_q;
  logic               bb_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  next_addr_q;
  logic [RW-1:0]      req_cnt_q;
  logic [PCW-1:0]     pop_cnt_q;
  logic               sw_l_q;
  logic               sw_h_q;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic [CW-1:0]      outst_q;
  logic [CW-1:0]      outst_d;

  logic accept;
  logic push;
  logic pop;
  logic credit_ok;
  logic other_start;
  logic last_pop;

  assign accept      = req_q && avl_ready;
  // Beats with nothing outstanding are stale (issued before a reset) and are dropped.
  assign push        = avl_rdata_valid && (outst_q != '0);
  assign dat_en      = (count_q != '0);
  assign pop         = dat_en && dat_ready;
  assign credit_ok   = ({1'b0, count_q} + {1'b0, outst_q} + BURST_X) <= DEPTH_X;
  assign other_start = init_done && (half_q ? rd_start_l : rd_start_h);
  assign last_pop    = pop && (pop_cnt_q == LAST_POP);

  assign dat_out        = dat_en ? mem[rd_ptr_q] : '0;
  assign avl_addr       = addr_q;
  assign avl_read_req   = req_q;
  assign avl_burstbegin = bb_q;
  assign avl_size       = 4'(BURST);
  assign avl_be         = 8'hFF;
  assign read_switch_l  = sw_l_q;
  assign read_switch_h  = sw_h_q;
  assign busy           = busy_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    outst_d = outst_q;
    if (accept) begin
      outst_d = outst_d + BURST_C;
    end
    if (push) begin
      outst_d = outst_d - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= avl_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      outst_q <= outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      half_q      <= 1'b0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      bb_q        <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      req_cnt_q   <= '0;
      pop_cnt_q   <= '0;
      sw_l_q      <= 1'b0;
      sw_h_q      <= 1'b0;
    end else begin
      sw_l_q <= 1'b0;
      sw_h_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_done && (rd_start_l || rd_start_h)) begin
            state_q     <= S_REQ;
            half_q      <= !rd_start_l;
            next_addr_q <= rd_start_l ? L_ADDR : H_ADDR;
            req_cnt_q   <= '0;
            pop_cnt_q   <= '0;
            busy_q      <= 1'b1;
            pend_q      <= rd_start_l && rd_start_h;
          end
        end
        S_REQ: begin
          if (other_start) begin
            pend_q <= 1'b1;
          end
          if (pop) begin
            pop_cnt_q <= pop_cnt_q + 1'b1;
          end
          if (!req_q) begin
            if (credit_ok) begin
              req_q  <= 1'b1;
              bb_q   <= 1'b1;
              addr_q <= next_addr_q;
            end
          end else begin
            // Request and address stay frozen until the slave takes them.
            bb_q <= 1'b0;
            if (avl_ready) begin
              req_q       <= 1'b0;
              next_addr_q <= next_addr_q + BURST_A;
              req_cnt_q   <= req_cnt_q + 1'b1;
              if (req_cnt_q == LAST_REQ) begin
                state_q <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (other_start) begin
            pend_q <= 1'b1;
          end
          if (pop) begin
            pop_cnt_q <= pop_cnt_q + 1'b1;
          end
          if (last_pop) begin
            sw_l_q    <= !half_q;
            sw_h_q    <= half_q;
            pop_cnt_q <= '0;
            req_cnt_q <= '0;
            pend_q    <= 1'b0;
            if (pend_q || other_start) begin
              state_q     <= S_REQ;
              half_q      <= !half_q;
              next_addr_q <= half_q ? L_ADDR : H_ADDR;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_reader.sv
// Directed/randomised bench for ddr_burst_reader: an Avalon slave with random latency
// and a word-stream reference model built from region bases and start/pending rules.
module tb_ddr_burst_reader;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 64;
  localparam int BURST  = 4;
  localparam int RWORDS = 4096;
  localparam int LB     = 0;
  localparam int HB     = 4096;
  localparam int DEPTH  = 16;
  localparam int NREQ   = RWORDS / BURST;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic              rd_start_l;
  logic              rd_start_h;
  logic              avl_ready;
  logic [ADDR_W-1:0] avl_addr;
  logic              avl_read_req;
  logic              avl_burstbegin;
  logic [3:0]        avl_size;
  logic [7:0]        avl_be;
  logic [DATA_W-1:0] avl_rdata;
  logic              avl_rdata_valid;
  logic [DATA_W-1:0] dat_out;
  logic              dat_en;
  logic              dat_ready;
  logic              read_switch_l;
  logic              read_switch_h;
  logic              busy;

  always #5 clk = ~clk;

  ddr_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .REGION_WORDS(RWORDS),
    .L_BASE(LB), .H_BASE(HB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_start_l(rd_start_l), .rd_start_h(rd_start_h),
    .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_read_req(avl_read_req),
    .avl_burstbegin(avl_burstbegin), .avl_size(avl_size), .avl_be(avl_be),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .dat_out(dat_out), .dat_en(dat_en), .dat_ready(dat_ready),
    .read_switch_l(read_switch_l), .read_switch_h(read_switch_h), .busy(busy)
  );

  typedef struct {
    int addr;
    int due;
    int ep;
  } beat_t;

  beat_t bq[$];
  int    exp_req_q[$];
  int    exp_word_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int epoch   = 0;
  int tb_fifo = 0;
  int tb_outst = 0;
  int active  = 0;
  bit pend    = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_sw_l = 1'b0;
  bit exp_sw_h = 1'b0;
  bit prev_req = 1'b0;
  bit prev_acc = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int p_ready  = 100;
  int p_valid  = 100;
  int p_dready = 100;
  bit st_l = 1'b0;
  bit st_h = 1'b0;
  bit rst_req = 1'b1;

  function automatic logic [63:0] word_of(input int a);
    return {32'(a) ^ 32'hC0DE_0000, 32'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_bound(input string tag, input int used, input int budget);
    n_tests++;
    assert (used < budget) else begin
      n_fail++;
      $error("FAIL %s: observed %0d cycles expected fewer than %0d", tag, used, budget);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req", avl_read_req, 0);
    chk("rst_bb", avl_burstbegin, 0);
    chk("rst_addr", avl_addr, 0);
    chk("rst_size", avl_size, BURST);
    chk("rst_be", avl_be, 8'hFF);
    chk("rst_dat_out", dat_out, 0);
    chk("rst_dat_en", dat_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sw", {read_switch_h, read_switch_l}, 0);
  endtask

  task automatic activate(input int h);
    int base;
    base = (h == 1) ? LB : HB;
    active = h;
    exp_busy = 1'b1;
    for (int k = 0; k < NREQ; k++) exp_req_q.push_back(base + k * BURST);
    for (int k = 0; k < RWORDS; k++) exp_word_q.push_back(base + k);
  endtask

  task automatic finish_half(input bit hi);
    $display("[TB] cycle %0d: %s half delivered", cyc, hi ? "high" : "low");
    if (hi) exp_sw_h = 1'b1;
    else    exp_sw_l = 1'b1;
    active = 0;
    exp_busy = 1'b0;
    if (pend) begin
      pend = 1'b0;
      activate(hi ? 1 : 2);
    end
  endtask

  task automatic model_reset();
    epoch++;
    exp_req_q.delete();
    exp_word_q.delete();
    active = 0;
    pend = 1'b0;
    exp_busy = 1'b0;
    tb_fifo = 0;
    tb_outst = 0;
  endtask

  // One clock: check the state left by the last edge, then drive the next one.
  task automatic step();
    bit    acc;
    int    w;
    beat_t b;
    @(negedge clk);
    cyc++;
    if (rst) check_reset_vals();
    chk("busy", busy, exp_busy);
    chk("dat_en", dat_en, tb_fifo != 0);
    chk("switch_l", read_switch_l, exp_sw_l);
    chk("switch_h", read_switch_h, exp_sw_h);
    if (!exp_busy) chk("idle_no_req", avl_read_req, 0);
    if (prev_req && !prev_acc) begin
      chk("req_held", avl_read_req, 1);
      chk("addr_held", avl_addr, prev_addr);
      chk("bb_once", avl_burstbegin, 0);
    end else begin
      chk("bb_first", avl_burstbegin, avl_read_req);
    end
    exp_sw_l = 1'b0;
    exp_sw_h = 1'b0;

    rst = rst_req;
    rd_start_l = st_l;
    rd_start_h = st_h;
    acc = 1'b0;
    if (rst) begin
      avl_ready = 1'b0;
      model_reset();
    end else begin
      avl_ready = ($urandom_range(99) < p_ready);
      acc = avl_read_req && avl_ready;
    end

    if (acc) begin
      n_acc++;
      w = (exp_req_q.size() != 0) ? exp_req_q.pop_front() : -1;
      chk("req_addr", avl_addr, w);
      for (int k = 0; k < BURST; k++) begin
        bq.push_back('{addr: int'(avl_addr) + k, due: cyc + $urandom_range(1, 5), ep: epoch});
      end
      tb_outst += BURST;
      chk("credit", (tb_outst + tb_fifo) <= DEPTH, 1);
    end

    if (bq.size() != 0 && bq[0].due <= cyc && $urandom_range(99) < p_valid) begin
      b = bq.pop_front();
      avl_rdata_valid = 1'b1;
      avl_rdata = word_of(b.addr);
      if (b.ep == epoch && !rst) begin
        tb_fifo++;
        tb_outst--;
      end
    end else begin
      avl_rdata_valid = 1'b0;
      avl_rdata = {$urandom, $urandom};
    end

    dat_ready = ($urandom_range(99) < p_dready);
    if (!rst && dat_en && dat_ready) begin
      w = (exp_word_q.size() != 0) ? exp_word_q.pop_front() : -1;
      chk("dat_out", dat_out, word_of(w));
      tb_fifo--;
      if (w == LB + RWORDS - 1) finish_half(1'b0);
      else if (w == HB + RWORDS - 1) finish_half(1'b1);
    end

    if (!rst && init_done) begin
      if (active == 0) begin
        if (st_l) begin
          activate(1);
          if (st_h) pend = 1'b1;
        end else if (st_h) begin
          activate(2);
        end
      end else if ((active == 1 && st_h) || (active == 2 && st_l)) begin
        pend = 1'b1;
      end
    end
    st_l = 1'b0;
    st_h = 1'b0;

    prev_req  = rst ? 1'b0 : avl_read_req;
    prev_acc  = acc;
    prev_addr = avl_addr;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_busy || exp_word_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    chk_bound(tag, c, budget);
    repeat (3) step();
  endtask

  initial begin
    int c;
    int base_acc;
    rst = 1'b1;
    init_done = 1'b0;
    rd_start_l = 1'b0;
    rd_start_h = 1'b0;
    avl_ready = 1'b0;
    avl_rdata = '0;
    avl_rdata_valid = 1'b0;
    dat_ready = 1'b0;

    repeat (3) step();
    rst_req = 1'b0;
    repeat (2) step();

    // Start while calibration is still running must be ignored.
    base_acc = n_acc;
    st_h = 1'b1;
    step();
    repeat (20) step();
    chk("t5_no_req", n_acc - base_acc, 0);
    init_done = 1'b1;

    // Full low half with everything always ready.
    base_acc = n_acc;
    st_l = 1'b1;
    step();
    run_until_idle("t1_timeout", 12000);
    chk("t1_req_count", n_acc - base_acc, NREQ);

    // Consumer stalled: only as many bursts as the FIFO can hold.
    base_acc = n_acc;
    p_dready = 0;
    st_l = 1'b1;
    step();
    repeat (200) step();
    chk("t2_stall_reqs", n_acc - base_acc, DEPTH / BURST);
    chk("t2_stall_dat_en", dat_en, 1);
    p_dready = 70;
    p_valid = 80;
    run_until_idle("t2_timeout", 20000);

    // Slave holds off a presented request.
    p_ready = 0;
    st_l = 1'b1;
    step();
    c = 0;
    while (!avl_read_req && c < 50) begin
      step();
      c++;
    end
    chk_bound("t3_req_wait", c, 50);
    repeat (5) step();
    chk("t3_still_req", avl_read_req, 1);
    p_ready = 80;
    p_dready = 85;
    run_until_idle("t3_timeout", 20000);

    // Simultaneous starts: low served, high pending; extra low start ignored.
    base_acc = n_acc;
    st_l = 1'b1;
    st_h = 1'b1;
    step();
    repeat (30) step();
    st_l = 1'b1;
    step();
    run_until_idle("t4_timeout", 40000);
    chk("t4_req_count", n_acc - base_acc, 2 * NREQ);

    // Reset in the middle of a transfer with beats in flight.
    p_ready = 100;
    p_valid = 100;
    p_dready = 0;
    base_acc = n_acc;
    st_l = 1'b1;
    step();
    c = 0;
    while (n_acc - base_acc < 3 && c < 100) begin
      step();
      c++;
    end
    chk_bound("t6_acc_wait", c, 100);
    chk("t6_in_flight", bq.size() != 0, 1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (10) step();
    p_ready = 80;
    p_valid = 80;
    p_dready = 80;
    st_l = 1'b1;
    step();
    run_until_idle("t6_timeout", 20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
